trace_buffer_dump: RTL and testbench

- Readout stage directly downstream of the circular trace buffer.
- On a dump request it freezes tracing and walks all TB_SIZE entries through the buffer's read port (address out, vector back), starting from the oldest entry.
- Each N-lane vector is serialized into DATA_WIDTH-bit words on a valid/ready stream toward the host/JTAG bridge.
- Handles the buffer's fixed read latency and downstream backpressure.

---
 rtl/trace_buffer_dump_pkg.sv | 11 +
 rtl/trace_buffer_dump_vector_serializer.sv | 63 ++++++
 rtl/trace_buffer_dump.sv | 117 +++++++++++
 tb/tb_trace_buffer_dump.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/trace_buffer_dump_pkg.sv
// Shared types for the trace-buffer dump readout: FSM states and width helpers.
package trace_buffer_dump_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} dump_state_t;

  // Latency counter must be able to hold READ_LATENCY itself.
  function automatic int lat_width(input int read_latency);
    return $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/trace_buffer_dump_vector_serializer.sv
// Parallel-load N-lane vector, then emit lane 0..N-1 on a valid/ready stream.
module trace_buffer_dump_vector_serializer
  import trace_buffer_dump_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            is_final_i,
  input  logic            flush_i,
  input  logic [N*DW-1:0] vec_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  output logic            last_o,
  output logic            lane_done_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N*DW-1:0]  sh_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q, final_q, last_q;
  logic             accept;

  assign accept      = valid_q && ready_i;
  assign lane_done_o = accept && (idx_q == IDX_W'(N - 1));
  assign valid_o     = valid_q;
  assign data_o      = sh_q[DW-1:0];
  assign last_o      = last_q;

  // Lane 0 always sits in the low word, so data_o is a plain register slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      final_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      sh_q    <= vec_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
      final_q <= is_final_i;
      last_q  <= is_final_i && (N == 1);
    end else if (accept) begin
      sh_q  <= sh_q >> DW;
      idx_q <= idx_q + 1'b1;
      if (lane_done_o) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        last_q <= final_q && (idx_q == IDX_W'(N - 2));
      end
    end
  end

endmodule

// File: rtl/trace_buffer_dump.sv
// Trace-buffer dump: freezes tracing, walks every entry from the oldest one,
// and serializes each vector into DATA_WIDTH words toward the host bridge.
module trace_buffer_dump
  import trace_buffer_dump_pkg::*;
#(
  parameter int N            = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int TB_SIZE      = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       dump_start,
  input  logic                       dump_abort,
  input  logic [$clog2(TB_SIZE)-1:0] start_addr,
  output logic [$clog2(TB_SIZE)-1:0] tb_mem_address,
  input  logic [N*DATA_WIDTH-1:0]    tb_vector_in,
  output logic                       trace_freeze,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       dump_done
);

  localparam int ADDR_W = $clog2(TB_SIZE);
  localparam int LAT_W  = lat_width(READ_LATENCY);
  localparam int CNT_W  = ADDR_W + 1;

  dump_state_t       state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q;
  logic [CNT_W-1:0]  left_q;
  logic [LAT_W-1:0]  lat_q;
  logic              freeze_q, done_q;
  logic              data_ready, load, flush, lane_done;

  assign ptr_d          = ptr_q + 1'b1;
  assign flush          = dump_abort && (state_q != IDLE);
  // The READ cycle is latency cycle 1, so READ and WAIT share the capture test.
  assign data_ready     = ((state_q == READ) || (state_q == WAIT)) &&
                          (lat_q == LAT_W'(READ_LATENCY));
  assign load           = data_ready && !dump_abort;
  assign tb_mem_address = addr_q;
  assign trace_freeze   = freeze_q;
  assign dump_done      = done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      addr_q   <= '0;
      left_q   <= '0;
      lat_q    <= '0;
      freeze_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q  <= IDLE;
      freeze_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (dump_start) begin
          ptr_q    <= start_addr;
          addr_q   <= start_addr;
          left_q   <= CNT_W'(TB_SIZE);
          lat_q    <= LAT_W'(1);
          freeze_q <= 1'b1;
          state_q  <= READ;
        end
        READ, WAIT: begin
          if (data_ready) begin
            state_q <= OUT;
          end else begin
            lat_q   <= lat_q + 1'b1;
            state_q <= WAIT;
          end
        end
        OUT: if (lane_done) begin
          ptr_q  <= ptr_d;
          left_q <= left_q - 1'b1;
          if (left_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            addr_q  <= ptr_d;
            lat_q   <= LAT_W'(1);
            state_q <= READ;
          end
        end
        DONE: begin
          freeze_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  trace_buffer_dump_vector_serializer #(
    .N  (N),
    .DW (DATA_WIDTH)
  ) u_ser (
    .clk         (clk),
    .rst_n       (resetn),
    .load_i      (load),
    .is_final_i  (left_q == CNT_W'(1)),
    .flush_i     (flush),
    .vec_i       (tb_vector_in),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .last_o      (out_last),
    .lane_done_o (lane_done)
  );

endmodule

// File: tb/tb_trace_buffer_dump.sv
// Directed bench for trace_buffer_dump: N=4, 32-bit lanes, 8 entries, latency 2.
module tb_trace_buffer_dump;

  logic         clk, resetn, dump_start, dump_abort, out_ready;
  logic [2:0]   start_addr, tb_mem_address;
  logic [127:0] tb_vec;
  logic         trace_freeze, out_valid, out_last, dump_done;
  logic [31:0]  out_data;
  int           checks, errors;

  trace_buffer_dump #(.N(4), .DATA_WIDTH(32), .TB_SIZE(8), .READ_LATENCY(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .dump_start     (dump_start),
    .dump_abort     (dump_abort),
    .start_addr     (start_addr),
    .tb_mem_address (tb_mem_address),
    .tb_vector_in   (tb_vec),
    .trace_freeze   (trace_freeze),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .dump_done      (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: address cycle counts as latency cycle 1, data in cycle 2.
  always @(posedge clk)
    for (int j = 0; j < 4; j++) tb_vec[j*32 +: 32] <= {13'd0, tb_mem_address, 16'(j)};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full dump from sa; ready high pct% of cycles; optional stray dump_start.
  task automatic run_dump(input logic [2:0] sa, input int pct, input int pulse_cyc);
    int cyc, widx, first_v, done_cyc, frz_bad;
    logic pv, pr;
    logic [31:0] pd, exp_w;
    logic [2:0] ent;
    start_addr = sa;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    cyc = 1; widx = 0; first_v = -1; done_cyc = -1; frz_bad = 0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    while (cyc < 3000 && done_cyc < 0) begin
      dump_start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) start_addr = sa + 3'd3;
      out_ready = ($urandom_range(0, 99) < pct);
      if (!trace_freeze) frz_bad++;
      if (pv && !pr) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, pd);
      end
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        ent   = sa + 3'(widx / 4);
        exp_w = {13'd0, ent, 16'(widx % 4)};
        if (widx < 32) begin
          chk("word", out_data, exp_w);
          chk("last", 32'(out_last), 32'(widx == 31));
          if (widx % 4 == 0) chk("addr", 32'(tb_mem_address), 32'(ent));
        end
        if (out_ready) widx++;
      end
      if (dump_done) done_cyc = cyc;
      pv = out_valid; pr = out_ready; pd = out_data;
      step();
      cyc++;
    end
    dump_start = 1'b0;
    chk("word_count", widx, 32);
    chk("freeze_during", frz_bad, 0);
    chk("first_valid_cycle", first_v, 3);
    if (pct >= 100) chk("done_cycle", done_cyc, 49);
    else chk("done_seen", 32'(done_cyc > 0), 32'd1);
    chk("freeze_after", 32'(trace_freeze), 32'd0);
    chk("done_one_cycle", 32'(dump_done), 32'd0);
  endtask

  initial begin
    int widx, cyc, seen;
    checks = 0; errors = 0;
    resetn = 1'b0; dump_start = 1'b0; dump_abort = 1'b0;
    start_addr = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_addr", 32'(tb_mem_address), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_freeze", 32'(trace_freeze), 32'd0);
    resetn = 1'b1;
    step();

    run_dump(3'd0, 100, 0);
    run_dump(3'd5, 100, 0);
    run_dump(3'd1, 30, 0);

    // Abort while lane 2 of the fourth entry (address 5) is presented.
    out_ready = 1'b1;
    start_addr = 3'd2;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    widx = 0; cyc = 0;
    while (cyc < 200 && !(out_valid && widx == 14)) begin
      if (out_valid) widx++;
      step();
      cyc++;
    end
    chk("abort_reach", widx, 14);
    chk("abort_word", out_data, 32'h0005_0002);
    dump_abort = 1'b1;
    step();
    dump_abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_freeze", 32'(trace_freeze), 32'd0);
    seen = 0;
    repeat (10) begin
      if (dump_done || out_valid || trace_freeze) seen = 1;
      step();
    end
    chk("abort_quiet", seen, 0);
    run_dump(3'd6, 100, 0);

    run_dump(3'd4, 100, 25);

    // Reset asserted during WAIT.
    start_addr = 3'd3;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    chk("pre_rst_freeze", 32'(trace_freeze), 32'd1);
    chk("pre_rst_addr", 32'(tb_mem_address), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("arst_addr", 32'(tb_mem_address), 32'd0);
    chk("arst_freeze", 32'(trace_freeze), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_done", 32'(dump_done), 32'd0);
    step();
    resetn = 1'b1;
    seen = 0;
    repeat (8) begin
      if (out_valid || trace_freeze || dump_done || tb_mem_address != 3'd0) seen = 1;
      step();
    end
    chk("post_rst_idle", seen, 0);

    run_dump(3'd7, 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
